rv_fetch_ctrl: RTL and testbench

Program-counter register and instruction-fetch sequencer directly downstream of rv_nextpc_gen. Holds the architectural PC and issues one fetch per instruction to instruction memory over a valid/ready request and a valid response. Presents the fetched word to decode, then loads the next PC from rv_nextpc_gen's nextpc when the core commits. It also detects misaligned targets, imem errors and fetch timeouts, and counts retired instructions.

---
 rtl/rv_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_rv_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_ctrl.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Fetches at pc, hands the word to decode, and then loads the committed next PC.
module rv_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 64,
  parameter int          CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_pc,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_ISSUE, S_EXEC, S_FAULT} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wd;
  logic             wd_clr, wd_inc, load_inst, commit, advance, set_fault;
  logic [1:0]       code_next;
  logic [31:0]      fpc_next, target;

  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_ISSUE);
  assign imem_req_addr  = pc;
  assign fault          = (state == S_FAULT);

  // jalr semantics: bit 0 of the committed target is always cleared
  assign target = npc & ~32'h1;

  always_comb begin
    state_next = state;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    load_inst  = 1'b0;
    commit     = 1'b0;
    advance    = 1'b0;
    set_fault  = 1'b0;
    code_next  = 2'b00;
    fpc_next   = 32'h0;
    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          state_next = S_WAIT;
          wd_clr     = 1'b1;
        end
      end
      S_WAIT: begin
        // A response in the final watchdog cycle takes priority over the timeout
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_next = S_FAULT;
            set_fault  = 1'b1;
            code_next  = 2'b11;
            fpc_next   = pc;
          end else begin
            state_next = S_ISSUE;
            load_inst  = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (wd == WD_LAST)) begin
          state_next = S_FAULT;
          set_fault  = 1'b1;
          code_next  = 2'b10;
          fpc_next   = pc;
        end else begin
          wd_inc = 1'b1;
        end
      end
      S_ISSUE: begin
        if (inst_ready) begin
          if (npc_valid) commit = 1'b1;
          else           state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (npc_valid) commit = 1'b1;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_REQ;
    endcase

    if (commit) begin
      if (target[1]) begin
        state_next = S_FAULT;
        set_fault  = 1'b1;
        code_next  = 2'b01;
        fpc_next   = target;
      end else begin
        state_next = S_REQ;
        advance    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      instret    <= 64'h0;
      fault_code <= 2'b00;
      fault_pc   <= 32'h0;
      wd         <= '0;
    end else begin
      state <= state_next;
      if (wd_clr)      wd <= '0;
      else if (wd_inc) wd <= wd + 1'b1;
      if (load_inst) inst <= imem_rsp_data;
      if (advance) begin
        pc      <= target;
        instret <= instret + 64'd1;
      end
      if (set_fault) begin
        fault_code <= code_next;
        fault_pc   <= fpc_next;
      end
    end
  end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Scoreboard bench for rv_fetch_ctrl: expected fetch addresses and instruction
// words are queued as stimulus is driven and compared when the DUT presents them.
module tb_rv_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc, npc, fault_pc;
  logic        npc_valid, fault;
  logic [1:0]  fault_code;
  logic [63:0] instret;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] addrQ[$];
  logic [31:0] instQ[$];
  logic [63:0] expInstret;

  rv_fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .pc(pc), .npc_valid(npc_valid), .npc(npc),
    .fault(fault), .fault_code(fault_code), .fault_pc(fault_pc),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic queueUnderflow(input string tag);
    checks++;
    errors++;
    $display("[TB] FAIL %s: scoreboard queue empty when DUT produced output", tag);
  endtask

  task automatic doReset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    imem_rsp_err = 1'b0; inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;
    step();
    step();
    rst = 1'b0;
    addrQ.delete();
    instQ.delete();
    addrQ.push_back(RESET_PC);
    expInstret = 64'd0;
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_inst", inst, 0);
    checkOutput("rst_instret", instret, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_code", fault_code, 0);
    checkOutput("rst_fault_pc", fault_pc, 0);
    checkOutput("rst_req_valid", imem_req_valid, 1);
    checkOutput("rst_inst_valid", inst_valid, 0);
  endtask

  task automatic reqPhase(input int stall);
    logic [31:0] exp;
    if (addrQ.size() == 0) begin
      queueUnderflow("req_addr");
      return;
    end
    exp = addrQ.pop_front();
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      checkOutput("req_valid_hold", imem_req_valid, 1);
      checkOutput("req_addr_hold", imem_req_addr, exp);
      step();
    end
    checkOutput("req_valid", imem_req_valid, 1);
    checkOutput("req_addr", imem_req_addr, exp);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    checkOutput("wait_no_req", imem_req_valid, 0);
  endtask

  task automatic rspPhase(input logic [31:0] data, input logic err);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    if (!err) instQ.push_back(data);
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
  endtask

  task automatic waitNoRsp(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("wait_no_fault", fault, 0);
      checkOutput("wait_no_inst", inst_valid, 0);
      step();
    end
  endtask

  task automatic issuePhase(input int stall, input logic same, input logic [31:0] npcv,
                            input int execDelay);
    logic [31:0] exp, t;
    if (instQ.size() == 0) begin
      queueUnderflow("inst");
      return;
    end
    exp = instQ.pop_front();
    // Stray npc_valid and responses while decode stalls must not disturb anything
    for (int i = 0; i < stall; i++) begin
      inst_ready = 1'b0;
      npc_valid = 1'b1; npc = 32'hdead_0000;
      imem_rsp_valid = 1'b1; imem_rsp_data = ~exp;
      checkOutput("inst_valid_hold", inst_valid, 1);
      checkOutput("inst_hold", inst, exp);
      step();
    end
    npc_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    checkOutput("inst_valid", inst_valid, 1);
    checkOutput("inst", inst, exp);
    inst_ready = 1'b1;
    npc_valid = same;
    npc = npcv;
    step();
    inst_ready = 1'b0;
    npc_valid = 1'b0;
    if (!same) begin
      for (int i = 0; i < execDelay; i++) begin
        checkOutput("exec_no_inst", inst_valid, 0);
        checkOutput("exec_no_req", imem_req_valid, 0);
        step();
      end
      npc_valid = 1'b1;
      npc = npcv;
      step();
      npc_valid = 1'b0;
    end
    t = npcv & ~32'h1;
    if (!t[1]) begin
      addrQ.push_back(t);
      expInstret = expInstret + 64'd1;
      checkOutput("commit_pc", pc, t);
      checkOutput("commit_instret", instret, expInstret);
      checkOutput("commit_no_fault", fault, 0);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [31:0] npcv);
    reqPhase(0);
    rspPhase(data, 1'b0);
    issuePhase(0, 1'b1, npcv, 0);
  endtask

  task automatic checkFault(input logic [1:0] code, input logic [31:0] fpc, input logic [31:0] pcExp);
    checkOutput("fault", fault, 1);
    checkOutput("fault_code", fault_code, code);
    checkOutput("fault_pc", fault_pc, fpc);
    checkOutput("fault_pc_held", pc, pcExp);
    checkOutput("fault_instret", instret, expInstret);
    // Terminal state: everything driven at it is ignored
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1;
    inst_ready = 1'b1; npc_valid = 1'b1; npc = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("fault_sticky", fault, 1);
      checkOutput("fault_code_held", fault_code, code);
      checkOutput("fault_no_req", imem_req_valid, 0);
      checkOutput("fault_no_inst", inst_valid, 0);
    end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    inst_ready = 1'b0; npc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Sequential fetch, three cycles per instruction
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(32'h0000_0013 + 32'(i << 8), 32'(4 * (i + 1)));
    checkOutput("instret_4", instret, 4);

    // Stalled request, stalled decode, delayed commit
    reqPhase(5);
    rspPhase(32'ha5a5_0013, 1'b0);
    issuePhase(3, 1'b0, 32'h0000_0100, 1);

    // Misaligned jalr target
    applyStimulus(32'h0000_0067, 32'h0000_0203);
    checkFault(2'b01, 32'h0000_0202, 32'h0000_0100);

    // Odd but word-aligned-after-clear target is fine
    doReset();
    applyStimulus(32'h0000_0067, 32'h0000_0205);

    // Watchdog expires after 64 silent cycles
    reqPhase(0);
    waitNoRsp(TIMEOUT - 1);
    step();
    checkFault(2'b10, 32'h0000_0204, 32'h0000_0204);

    // Response in the last watchdog cycle wins
    doReset();
    reqPhase(0);
    waitNoRsp(TIMEOUT - 1);
    rspPhase(32'h1234_5678, 1'b0);
    issuePhase(0, 1'b1, 32'h0000_0004, 0);

    // Bus error at 0x40
    applyStimulus(32'h0000_0013, 32'h0000_0040);
    reqPhase(0);
    rspPhase(32'hffff_ffff, 1'b1);
    checkFault(2'b11, 32'h0000_0040, 32'h0000_0040);

    // Reset while waiting, then a late response right after reset
    doReset();
    applyStimulus(32'h0000_0013, 32'h0000_0008);
    reqPhase(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0bad_0bad;
    step();
    imem_rsp_valid = 1'b0;
    checkOutput("late_req_valid", imem_req_valid, 1);
    checkOutput("late_req_addr", imem_req_addr, RESET_PC);
    checkOutput("late_instret", instret, 0);
    checkOutput("late_inst", inst, 0);
    checkOutput("late_inst_valid", inst_valid, 0);
    checkOutput("late_fault", fault, 0);
    addrQ.delete();
    instQ.delete();
    addrQ.push_back(RESET_PC);
    expInstret = 64'd0;
    applyStimulus(32'h0000_0033, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
